// File: rtl/riscv_mem_arbiter.sv
// Two-port arbiter sharing a single-port, one-cycle-latency memory between the
// instruction-fetch and load/store requesters, with one transaction in flight.
module riscv_mem_arbiter #(
    parameter int unsigned FIXED_DPRIO = 0
) (
    input  logic        clk,
    input  logic        rstn,

    input  logic        i_req_valid,
    output logic        i_req_ready,
    input  logic [31:0] i_req_addr,
    output logic        i_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] i_rsp_rdata,

    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic [31:0] d_req_addr,
    input  logic [3:0]  d_req_wstrb,
    input  logic [31:0] d_req_wdata,
    output logic        d_rsp_valid,
    input  logic        d_rsp_ready,
    output logic [31:0] d_rsp_rdata,

    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] PEND_IDLE  = 2'd0;
    localparam logic [1:0] PEND_RSP_I = 2'd1;
    localparam logic [1:0] PEND_RSP_D = 2'd2;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    logic [1:0] pend_q, pend_d;
    logic       last_q, last_d;
    logic       grant;
    logic       free;
    logic       issue_i;
    logic       issue_d;

    // The response slot frees up in the same cycle its consumer accepts it,
    // which is what allows back-to-back issue at one transaction per cycle.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block can leave it unassigned and infer a latch.
        free = 1'b0;
        case (pend_q)
            PEND_IDLE:  free = 1'b1;
            PEND_RSP_I: free = i_rsp_ready;
            PEND_RSP_D: free = d_rsp_ready;
            default:    free = 1'b1;
        endcase
    end

    always_comb begin
        grant = GNT_I;
        if (i_req_valid && d_req_valid) begin
            grant = (FIXED_DPRIO != 0) ? GNT_D : ~last_q;
        end else if (d_req_valid) begin
            grant = GNT_D;
        end
    end

    // Gating with rstn keeps every handshake and memory strobe quiet while
    // reset is asserted, independent of what the state registers hold.
    assign issue_i = rstn & free & (grant == GNT_I) & i_req_valid;
    assign issue_d = rstn & free & (grant == GNT_D) & d_req_valid;

    assign i_req_ready = issue_i;
    assign d_req_ready = issue_d;

    assign i_rsp_valid = rstn & (pend_q == PEND_RSP_I);
    assign d_rsp_valid = rstn & (pend_q == PEND_RSP_D);
    assign i_rsp_rdata = mem_rdata;
    assign d_rsp_rdata = mem_rdata;

    always_comb begin
        mem_addr  = '0;
        mem_read  = 1'b0;
        mem_wstrb = '0;
        mem_wdata = '0;
        if (issue_i) begin
            mem_addr = i_req_addr;
            mem_read = 1'b1;
        end else if (issue_d) begin
            mem_addr = d_req_addr;
            if (d_req_wstrb == 4'b0000) begin
                mem_read = 1'b1;
            end else begin
                mem_wstrb = d_req_wstrb;
                mem_wdata = d_req_wdata;
            end
        end
    end

    always_comb begin
        pend_d = pend_q;
        last_d = last_q;
        if (issue_i) begin
            pend_d = PEND_RSP_I;
            last_d = GNT_I;
        end else if (issue_d) begin
            pend_d = PEND_RSP_D;
            last_d = GNT_D;
        end else if (free) begin
            pend_d = PEND_IDLE;
        end
    end

    // last resets to D so that I wins the first tie after reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge value regardless of block ordering.
        if (!rstn) begin
            pend_q <= PEND_IDLE;
            last_q <= GNT_D;
        end else begin
            pend_q <= pend_d;
            last_q <= last_d;
        end
    end

    a_one_issue : assert property (@(posedge clk) disable iff (!rstn)
        !(issue_i && issue_d));

    a_no_issue_while_stalled : assert property (@(posedge clk) disable iff (!rstn)
        ((i_rsp_valid && !i_rsp_ready) || (d_rsp_valid && !d_rsp_ready))
        |-> !(mem_read || (mem_wstrb != 4'b0000)));

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed self-checking bench for riscv_mem_arbiter: one round-robin instance
// on a behavioural memory, plus a fixed-D-priority instance for grant checks.
module tb_riscv_mem_arbiter;

    localparam logic [31:0] W10 = 32'hDEAD_0010;
    localparam logic [31:0] W20 = 32'h1122_3344;
    localparam logic [31:0] W30 = 32'hC0DE_0030;
    localparam logic [31:0] W34 = 32'hC0DE_0034;

    logic        clk = 1'b0;
    logic        rstn;
    logic        i_req_valid, i_rsp_ready;
    logic [31:0] i_req_addr;
    logic        d_req_valid, d_rsp_ready;
    logic [31:0] d_req_addr, d_req_wdata;
    logic [3:0]  d_req_wstrb;

    logic        i_req_ready, i_rsp_valid, d_req_ready, d_rsp_valid;
    logic [31:0] i_rsp_rdata, d_rsp_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read;
    logic [3:0]  mem_wstrb;

    logic        i_req_ready_p, i_rsp_valid_p, d_req_ready_p, d_rsp_valid_p;
    logic [31:0] i_rsp_rdata_p, d_rsp_rdata_p;
    logic [31:0] mem_addr_p, mem_wdata_p;
    logic        mem_read_p;
    logic [3:0]  mem_wstrb_p;
    logic [31:0] mem_rdata_p;

    logic [31:0] mem [0:63];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    riscv_mem_arbiter #(.FIXED_DPRIO(0)) u_dut (
        .clk(clk), .rstn(rstn),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
        .i_rsp_valid(i_rsp_valid), .i_rsp_ready(i_rsp_ready), .i_rsp_rdata(i_rsp_rdata),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
        .d_req_wstrb(d_req_wstrb), .d_req_wdata(d_req_wdata),
        .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready), .d_rsp_rdata(d_rsp_rdata),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    riscv_mem_arbiter #(.FIXED_DPRIO(1)) u_dut_prio (
        .clk(clk), .rstn(rstn),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready_p), .i_req_addr(i_req_addr),
        .i_rsp_valid(i_rsp_valid_p), .i_rsp_ready(i_rsp_ready), .i_rsp_rdata(i_rsp_rdata_p),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready_p), .d_req_addr(d_req_addr),
        .d_req_wstrb(d_req_wstrb), .d_req_wdata(d_req_wdata),
        .d_rsp_valid(d_rsp_valid_p), .d_rsp_ready(d_rsp_ready), .d_rsp_rdata(d_rsp_rdata_p),
        .mem_addr(mem_addr_p), .mem_read(mem_read_p), .mem_wstrb(mem_wstrb_p),
        .mem_wdata(mem_wdata_p), .mem_rdata(mem_rdata_p)
    );

    assign mem_rdata_p = 32'h0;

    initial begin
        for (int k = 0; k < 64; k++) mem[k] = 32'h0;
        mem[4]  = W10;
        mem[8]  = W20;
        mem[12] = W30;
        mem[13] = W34;
        mem_rdata = 32'h0;
    end

    // One-cycle-latency memory: read data registered and held until the next read.
    always @(posedge clk) begin
        if (mem_read) mem_rdata <= mem[mem_addr[7:2]];
        for (int b = 0; b < 4; b++) begin
            if (mem_wstrb[b]) mem[mem_addr[7:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        logic exp_i;
        logic prev_i;

        rstn        = 1'b0;
        i_req_valid = 1'b1;
        i_req_addr  = 32'h10;
        i_rsp_ready = 1'b0;
        d_req_valid = 1'b1;
        d_req_addr  = 32'h20;
        d_req_wstrb = 4'b0011;
        d_req_wdata = 32'h5555_5555;
        d_rsp_ready = 1'b0;

        // Reset cycle: everything quiet even with requests presented.
        tick();
        tick();
        check("rst_i_req_ready", {31'b0, i_req_ready}, 32'h0);
        check("rst_d_req_ready", {31'b0, d_req_ready}, 32'h0);
        check("rst_i_rsp_valid", {31'b0, i_rsp_valid}, 32'h0);
        check("rst_d_rsp_valid", {31'b0, d_rsp_valid}, 32'h0);
        check("rst_mem_read", {31'b0, mem_read}, 32'h0);
        check("rst_mem_wstrb", {28'b0, mem_wstrb}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);

        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
        rstn        = 1'b1;
        tick();

        // Single fetch.
        i_req_valid = 1'b1;
        i_req_addr  = 32'h10;
        i_rsp_ready = 1'b1;
        settle();
        check("f_i_req_ready", {31'b0, i_req_ready}, 32'h1);
        check("f_mem_read", {31'b0, mem_read}, 32'h1);
        check("f_mem_addr", mem_addr, 32'h10);
        check("f_mem_wstrb", {28'b0, mem_wstrb}, 32'h0);
        tick();
        i_req_valid = 1'b0;
        settle();
        check("f_i_rsp_valid", {31'b0, i_rsp_valid}, 32'h1);
        check("f_i_rsp_rdata", i_rsp_rdata, W10);
        check("f_d_rsp_valid", {31'b0, d_rsp_valid}, 32'h0);
        tick();
        check("f_i_rsp_done", {31'b0, i_rsp_valid}, 32'h0);

        // Partial store, then load back the merged word.
        d_req_valid = 1'b1;
        d_req_addr  = 32'h20;
        d_req_wstrb = 4'b0011;
        d_req_wdata = 32'hAABB_CCDD;
        d_rsp_ready = 1'b1;
        settle();
        check("st_d_req_ready", {31'b0, d_req_ready}, 32'h1);
        check("st_mem_read", {31'b0, mem_read}, 32'h0);
        check("st_mem_wstrb", {28'b0, mem_wstrb}, 32'h3);
        check("st_mem_wdata", mem_wdata, 32'hAABB_CCDD);
        check("st_mem_addr", mem_addr, 32'h20);
        tick();
        d_req_wstrb = 4'b0000;
        d_req_wdata = 32'h0;
        settle();
        check("st_ack_valid", {31'b0, d_rsp_valid}, 32'h1);
        check("ld_d_req_ready", {31'b0, d_req_ready}, 32'h1);
        check("ld_mem_read", {31'b0, mem_read}, 32'h1);
        tick();
        d_req_valid = 1'b0;
        settle();
        check("ld_d_rsp_valid", {31'b0, d_rsp_valid}, 32'h1);
        check("ld_d_rsp_rdata", d_rsp_rdata, 32'h1122_CCDD);
        check("ld_i_rsp_valid", {31'b0, i_rsp_valid}, 32'h0);
        tick();

        // Contention: last grant was D, so I leads and grants alternate.
        i_req_valid = 1'b1;
        i_req_addr  = 32'h30;
        d_req_valid = 1'b1;
        d_req_addr  = 32'h34;
        exp_i  = 1'b1;
        prev_i = 1'b0;
        for (int c = 0; c < 6; c++) begin
            settle();
            check("rr_i_req_ready", {31'b0, i_req_ready}, {31'b0, exp_i});
            check("rr_d_req_ready", {31'b0, d_req_ready}, {31'b0, ~exp_i});
            check("rr_mem_read", {31'b0, mem_read}, 32'h1);
            check("rr_mem_addr", mem_addr, exp_i ? 32'h30 : 32'h34);
            check("dp_i_req_ready", {31'b0, i_req_ready_p}, 32'h0);
            check("dp_d_req_ready", {31'b0, d_req_ready_p}, 32'h1);
            check("dp_mem_addr", mem_addr_p, 32'h34);
            if (c > 0) begin
                check("rr_i_rsp_valid", {31'b0, i_rsp_valid}, {31'b0, prev_i});
                check("rr_d_rsp_valid", {31'b0, d_rsp_valid}, {31'b0, ~prev_i});
                check("rr_rsp_rdata", prev_i ? i_rsp_rdata : d_rsp_rdata, prev_i ? W30 : W34);
                check("dp_d_rsp_valid", {31'b0, d_rsp_valid_p}, 32'h1);
            end
            prev_i = exp_i;
            exp_i  = ~exp_i;
            tick();
        end
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
        tick();

        // Backpressure: a pending fetch response blocks D, whose payload wanders.
        i_req_valid = 1'b1;
        i_req_addr  = 32'h10;
        i_rsp_ready = 1'b0;
        settle();
        check("bp_i_req_ready", {31'b0, i_req_ready}, 32'h1);
        tick();
        i_req_valid = 1'b0;
        d_req_valid = 1'b1;
        d_req_wstrb = 4'b0000;
        for (int c = 0; c < 5; c++) begin
            d_req_addr = 32'h24 + 32'(4 * c);
            settle();
            check("bp_i_rsp_valid", {31'b0, i_rsp_valid}, 32'h1);
            check("bp_i_rsp_rdata", i_rsp_rdata, W10);
            check("bp_d_req_ready", {31'b0, d_req_ready}, 32'h0);
            check("bp_mem_read", {31'b0, mem_read}, 32'h0);
            tick();
        end
        d_req_addr  = 32'h20;
        i_rsp_ready = 1'b1;
        settle();
        check("bp_rel_d_req_ready", {31'b0, d_req_ready}, 32'h1);
        check("bp_rel_mem_read", {31'b0, mem_read}, 32'h1);
        check("bp_rel_mem_addr", mem_addr, 32'h20);
        tick();
        d_req_valid = 1'b0;
        settle();
        check("bp_d_rsp_valid", {31'b0, d_rsp_valid}, 32'h1);
        check("bp_d_rsp_rdata", d_rsp_rdata, 32'h1122_CCDD);
        check("bp_i_rsp_cleared", {31'b0, i_rsp_valid}, 32'h0);
        tick();

        // Reset the cycle after a fetch issue; last was I, reset must return it to D.
        i_req_valid = 1'b1;
        i_req_addr  = 32'h10;
        tick();
        i_req_valid = 1'b0;
        rstn        = 1'b0;
        settle();
        check("mr_rst_i_rsp_valid", {31'b0, i_rsp_valid}, 32'h0);
        tick();
        rstn        = 1'b1;
        i_req_valid = 1'b1;
        d_req_valid = 1'b1;
        d_req_addr  = 32'h20;
        settle();
        check("mr_i_rsp_valid", {31'b0, i_rsp_valid}, 32'h0);
        check("mr_d_rsp_valid", {31'b0, d_rsp_valid}, 32'h0);
        check("mr_tie_i_ready", {31'b0, i_req_ready}, 32'h1);
        check("mr_tie_d_ready", {31'b0, d_req_ready}, 32'h0);
        tick();
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
        tick();

        // Empty: no requests, nothing issued, nothing returned.
        for (int c = 0; c < 10; c++) begin
            settle();
            check("em_mem_read", {31'b0, mem_read}, 32'h0);
            check("em_mem_wstrb", {28'b0, mem_wstrb}, 32'h0);
            check("em_i_rsp_valid", {31'b0, i_rsp_valid}, 32'h0);
            check("em_d_rsp_valid", {31'b0, d_rsp_valid}, 32'h0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
